// File: rtl/mlp_inference_sequencer_if.sv
// Handshake and data bundle between the host/layer instances and the MLP inference sequencer.
// The master modport is the host/layer side and the slave modport is the sequencer.
interface mlp_inference_sequencer_if #(
   parameter int NUM_CLASSES = 10,
   parameter int DATA_W      = 16,
   parameter int IDX_W       = 4
);
   logic                     start;
   logic                     busy;
   logic                     l1_enable;
   logic                     l1_done;
   logic                     l2_enable;
   logic                     l2_done;
   logic signed [DATA_W-1:0] l2_out [NUM_CLASSES];
   logic [IDX_W-1:0]         class_idx;
   logic signed [DATA_W-1:0] class_score;
   logic                     done;
   logic                     error;

   modport master (
      output start, l1_done, l2_done, l2_out,
      input  busy, l1_enable, l2_enable, class_idx, class_score, done, error
   );

   modport slave (
      input  start, l1_done, l2_done, l2_out,
      output busy, l1_enable, l2_enable, class_idx, class_score, done, error
   );
endinterface

// File: rtl/mlp_inference_sequencer.sv
// Two-layer MLP inference controller: sequences layer 1 then layer 2, snapshots layer-2 outputs, sequential argmax.
// Optional per-layer watchdog enabled by defining MLP_SEQ_TIMEOUT_EN.
module mlp_inference_sequencer #(
   parameter int NUM_CLASSES = 10,
   parameter int DATA_W      = 16,
   parameter int IDX_W       = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input logic                     clk,
   input logic                     reset,
   mlp_inference_sequencer_if.slave bus
);

   if (NUM_CLASSES < 2) begin : g_chk_classes
      $error("NUM_CLASSES must be at least 2");
   end
   if ((1 << IDX_W) < NUM_CLASSES) begin : g_chk_idx_w
      $error("IDX_W too narrow for NUM_CLASSES");
   end
   if (TIMEOUT_CYC < 1) begin : g_chk_timeout
      $error("TIMEOUT_CYC must be at least 1");
   end

   typedef enum logic [2:0] {IDLE, L1_RUN, L2_RUN, ARGMAX, DONE} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

   state_t state_reg, state_next;

   logic signed [DATA_W-1:0] snap_reg [NUM_CLASSES];
   logic signed [DATA_W-1:0] best_val_reg;
   logic [IDX_W-1:0]         best_idx_reg;
   logic [IDX_W-1:0]         scan_idx_reg;

   logic                     l1_enable_reg, l1_enable_next;
   logic                     l2_enable_reg, l2_enable_next;
   logic                     busy_reg, busy_next;
   logic                     done_reg, done_next;
   logic [IDX_W-1:0]         class_idx_reg, class_idx_next;
   logic signed [DATA_W-1:0] class_score_reg, class_score_next;

   logic capture;
   logic start_accept;
   logic last_scan;
   logic timeout;
   logic error_flag;

   assign capture      = (state_reg == L2_RUN) && bus.l2_done;
   assign start_accept = (state_reg == IDLE) && bus.start;
   assign last_scan    = (scan_idx_reg == LAST_IDX);

`ifdef MLP_SEQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cyc_cnt_reg;
   logic             error_reg;
   logic             layer_entry;
   logic             layer_running;

   assign layer_entry   = ((state_next == L1_RUN) && (state_reg != L1_RUN)) ||
                          ((state_next == L2_RUN) && (state_reg != L2_RUN));
   assign layer_running = (state_reg == L1_RUN) || (state_reg == L2_RUN);

   // Fires in the last allowed cycle of a layer run if that layer has not reported done.
   assign timeout = (cyc_cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) &&
                    (((state_reg == L1_RUN) && !bus.l1_done) ||
                     ((state_reg == L2_RUN) && !bus.l2_done));

   always_ff @(posedge clk) begin
      if (reset) begin
         cyc_cnt_reg <= '0;
      end else if (layer_entry) begin
         cyc_cnt_reg <= '0;
      end else if (layer_running) begin
         cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         error_reg <= 1'b0;
      end else if (start_accept) begin
         error_reg <= 1'b0;
      end else if (timeout) begin
         error_reg <= 1'b1;
      end
   end

   assign error_flag = error_reg;
`else
   assign timeout    = 1'b0;
   assign error_flag = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.start) state_next = L1_RUN;
         L1_RUN: begin
            if (bus.l1_done)  state_next = L2_RUN;
            else if (timeout) state_next = DONE;
         end
         L2_RUN: begin
            if (bus.l2_done)  state_next = ARGMAX;
            else if (timeout) state_next = DONE;
         end
         ARGMAX:  if (last_scan) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are looked ahead from state_next so the registered enables line up with the state.
   always_comb begin
      l1_enable_next   = (state_next == L1_RUN);
      l2_enable_next   = (state_next == L2_RUN);
      busy_next        = (state_next != IDLE);
      done_next        = (state_reg == DONE);
      class_idx_next   = class_idx_reg;
      class_score_next = class_score_reg;
      if ((state_reg == DONE) && !error_flag) begin
         class_idx_next   = best_idx_reg;
         class_score_next = best_val_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         l1_enable_reg   <= 1'b0;
         l2_enable_reg   <= 1'b0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
         class_idx_reg   <= '0;
         class_score_reg <= '0;
      end else begin
         l1_enable_reg   <= l1_enable_next;
         l2_enable_reg   <= l2_enable_next;
         busy_reg        <= busy_next;
         done_reg        <= done_next;
         class_idx_reg   <= class_idx_next;
         class_score_reg <= class_score_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_snap
         always_ff @(posedge clk) begin
            if (reset) begin
               snap_reg[gi] <= '0;
            end else if (capture) begin
               snap_reg[gi] <= bus.l2_out[gi];
            end
         end
      end
   endgenerate

   // Strictly-greater signed compare so ties keep the lower index.
   always_ff @(posedge clk) begin
      if (reset) begin
         best_val_reg <= '0;
         best_idx_reg <= '0;
         scan_idx_reg <= '0;
      end else if (capture) begin
         best_val_reg <= bus.l2_out[0];
         best_idx_reg <= '0;
         scan_idx_reg <= IDX_W'(1);
      end else if (state_reg == ARGMAX) begin
         if (snap_reg[scan_idx_reg] > best_val_reg) begin
            best_val_reg <= snap_reg[scan_idx_reg];
            best_idx_reg <= scan_idx_reg;
         end
         scan_idx_reg <= scan_idx_reg + 1'b1;
      end
   end

   assign bus.l1_enable   = l1_enable_reg;
   assign bus.l2_enable   = l2_enable_reg;
   assign bus.busy        = busy_reg;
   assign bus.done        = done_reg;
   assign bus.class_idx   = class_idx_reg;
   assign bus.class_score = class_score_reg;
   assign bus.error       = error_flag;

endmodule

// File: tb/tb_mlp_inference_sequencer.sv
// Self-checking bench for mlp_inference_sequencer: directed and randomized inferences against an argmax model.
// The watchdog scenario is exercised only when MLP_SEQ_TIMEOUT_EN is defined.
module tb_mlp_inference_sequencer;
   localparam int N  = 10;
   localparam int DW = 16;
   localparam int IW = 4;

   typedef logic signed [DW-1:0] vec_t [N];

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mlp_inference_sequencer_if #(.NUM_CLASSES(N), .DATA_W(DW), .IDX_W(IW)) bus ();

   mlp_inference_sequencer #(
      .NUM_CLASSES(N), .DATA_W(DW), .IDX_W(IW), .TIMEOUT_CYC(16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int both_en_cycles = 0;
   int done_pulses = 0;

   always @(negedge clk) begin
      if (bus.l1_enable === 1'b1 && bus.l2_enable === 1'b1) both_en_cycles++;
      if (bus.done === 1'b1) done_pulses++;
   end

   int obs_lat, obs_idx, obs_score, obs_mid_idx, obs_done_delta, obs_err;
   bit obs_seq_bad, obs_busy_after;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: largest value, then the lowest index holding it.
   function automatic void model(input vec_t v, output int idx, output int score);
      int mx;
      mx = int'(v[0]);
      for (int i = 1; i < N; i++) if (int'(v[i]) > mx) mx = int'(v[i]);
      idx = -1;
      for (int i = N - 1; i >= 0; i--) if (int'(v[i]) == mx) idx = i;
      score = mx;
   endfunction

   // mode 0: pulse start; 1: start already held high; 2: L1_RUN already entered
   task automatic run_inf(input vec_t v, input int l1_lat, input int l2_lat,
                          input int mode, input bit scramble, input bit glitch);
      int d0;
      int n;
      d0 = done_pulses;
      obs_seq_bad = 1'b0;
      if (mode == 0) begin
         bus.start = 1'b1; tick(); bus.start = 1'b0;
      end else if (mode == 1) begin
         tick();
      end
      if (!(bus.l1_enable === 1'b1 && bus.l2_enable === 1'b0 && bus.busy === 1'b1)) obs_seq_bad = 1'b1;
      for (int i = 1; i < l1_lat; i++) begin
         if (glitch && i == 1) bus.l2_done = 1'b1;
         tick();
         bus.l2_done = 1'b0;
         if (bus.l1_enable !== 1'b1 || bus.l2_enable !== 1'b0) obs_seq_bad = 1'b1;
      end
      bus.l1_done = 1'b1; tick(); bus.l1_done = 1'b0;
      if (!(bus.l1_enable === 1'b0 && bus.l2_enable === 1'b1)) obs_seq_bad = 1'b1;
      for (int i = 1; i < l2_lat; i++) begin
         tick();
         if (bus.l2_enable !== 1'b1) obs_seq_bad = 1'b1;
      end
      for (int i = 0; i < N; i++) bus.l2_out[i] = v[i];
      bus.l2_done = 1'b1; tick(); bus.l2_done = 1'b0;
      if (bus.l2_enable !== 1'b0 || bus.l1_enable !== 1'b0) obs_seq_bad = 1'b1;
      obs_mid_idx = int'(bus.class_idx);
      if (scramble)
         for (int i = 0; i < N; i++) bus.l2_out[i] = DW'($urandom);
      n = 0;
      while (bus.done !== 1'b1 && n < 40) begin tick(); n++; end
      obs_lat   = n;
      obs_idx   = int'(bus.class_idx);
      obs_score = int'(bus.class_score);
      obs_err   = int'(bus.error);
      tick();
      obs_busy_after = bus.busy;
      obs_done_delta = done_pulses - d0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      checks++; if (bus.l1_enable !== 1'b0) begin errors++; $display("FAIL reset_l1_en got %b want 0", bus.l1_enable); end
      checks++; if (bus.l2_enable !== 1'b0) begin errors++; $display("FAIL reset_l2_en got %b want 0", bus.l2_enable); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
      checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", bus.error); end
      checks++; if (bus.class_idx !== '0) begin errors++; $display("FAIL reset_idx got %0d want 0", bus.class_idx); end
      checks++; if (bus.class_score !== '0) begin errors++; $display("FAIL reset_score got %0d want 0", bus.class_score); end
      tick();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_no_start busy got %b want 0", bus.busy); end
      $display("test_reset done");
   endtask

   task automatic test_basic();
      vec_t v;
      v = '{3, -2, 40, 7, 0, 1, 9, 12, 5, -8};
      both_en_cycles = 0;
      run_inf(v, 5, 3, 0, 1'b0, 1'b0);
      checks++; if (obs_seq_bad) begin errors++; $display("FAIL basic_seq got bad want ok"); end
      checks++; if (both_en_cycles != 0) begin errors++; $display("FAIL basic_excl got %0d overlap want 0", both_en_cycles); end
      checks++; if (obs_lat != 10) begin errors++; $display("FAIL basic_latency got %0d want 10", obs_lat); end
      checks++; if (obs_idx != 2) begin errors++; $display("FAIL basic_idx got %0d want 2", obs_idx); end
      checks++; if (obs_score != 40) begin errors++; $display("FAIL basic_score got %0d want 40", obs_score); end
      checks++; if (obs_busy_after !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", obs_busy_after); end
      checks++; if (obs_done_delta != 1) begin errors++; $display("FAIL basic_done_pulses got %0d want 1", obs_done_delta); end
      checks++; if (obs_err != 0) begin errors++; $display("FAIL basic_error got %0d want 0", obs_err); end
      $display("basic: idx %0d score %0d latency %0d", obs_idx, obs_score, obs_lat);
   endtask

   task automatic test_ties();
      vec_t v;
      int exp_idx [3];
      int exp_score [3];
      exp_idx   = '{0, 1, 9};
      exp_score = '{0, 9, -4};
      for (int t = 0; t < 3; t++) begin
         case (t)
            0:       v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
            1:       v = '{1, 9, 9, 2, 0, 0, 0, 0, 0, 9};
            default: v = '{-5, -5, -5, -5, -5, -5, -5, -5, -5, -4};
         endcase
         run_inf(v, 2, 2, 0, 1'b0, 1'b0);
         checks++; if (obs_idx != exp_idx[t]) begin errors++; $display("FAIL tie%0d_idx got %0d want %0d", t, obs_idx, exp_idx[t]); end
         checks++; if (obs_score != exp_score[t]) begin errors++; $display("FAIL tie%0d_score got %0d want %0d", t, obs_score, exp_score[t]); end
         $display("tie %0d: idx %0d score %0d", t, obs_idx, obs_score);
      end
   endtask

   task automatic test_ignored_inputs();
      vec_t v;
      int e_idx, e_score;
      // start held high across a whole run
      v = '{1, 2, 3, 4, 5, 6, 7, 8, 30, 0};
      model(v, e_idx, e_score);
      bus.start = 1'b1;
      run_inf(v, 3, 2, 1, 1'b0, 1'b0);
      checks++; if (obs_done_delta != 1) begin errors++; $display("FAIL held_done_pulses got %0d want 1", obs_done_delta); end
      checks++; if (obs_idx != e_idx) begin errors++; $display("FAIL held_idx got %0d want %0d", obs_idx, e_idx); end
      checks++; if (bus.l1_enable !== 1'b1) begin errors++; $display("FAIL held_restart l1_enable got %b want 1", bus.l1_enable); end
      bus.start = 1'b0;
      v = '{-1, 17, 3, 4, 5, 6, 7, 8, 9, 0};
      model(v, e_idx, e_score);
      run_inf(v, 2, 2, 2, 1'b0, 1'b0);
      checks++; if (obs_idx != e_idx || obs_score != e_score) begin errors++; $display("FAIL held_second got %0d/%0d want %0d/%0d", obs_idx, obs_score, e_idx, e_score); end
      $display("held start: second idx %0d score %0d", obs_idx, obs_score);
      // l2_done pulsed while layer 1 is still running
      v = '{0, 0, 0, 0, 0, 0, 22, 0, 0, 0};
      run_inf(v, 4, 2, 0, 1'b0, 1'b1);
      checks++; if (obs_seq_bad) begin errors++; $display("FAIL glitch_seq got bad want ok"); end
      checks++; if (obs_idx != 6) begin errors++; $display("FAIL glitch_idx got %0d want 6", obs_idx); end
      // l2_out scrambled after capture
      v = '{5, -7, 11, 3, 100, 2, -3, 99, 0, 1};
      run_inf(v, 2, 3, 0, 1'b1, 1'b0);
      checks++; if (obs_idx != 4 || obs_score != 100) begin errors++; $display("FAIL snapshot got %0d/%0d want 4/100", obs_idx, obs_score); end
      $display("snapshot: idx %0d score %0d", obs_idx, obs_score);
   endtask

   task automatic test_reset_mid();
      vec_t v;
      int d0;
      v = '{0, 0, 0, 0, 0, 0, 33, 0, 0, 0};
      run_inf(v, 2, 2, 0, 1'b0, 1'b0);
      for (int phase = 0; phase < 2; phase++) begin
         bus.start = 1'b1; tick(); bus.start = 1'b0;
         bus.l1_done = 1'b1; tick(); bus.l1_done = 1'b0;
         tick();
         if (phase == 1) begin
            for (int i = 0; i < N; i++) bus.l2_out[i] = v[i];
            bus.l2_done = 1'b1; tick(); bus.l2_done = 1'b0;
            repeat (3) tick();
         end
         d0 = done_pulses;
         reset = 1'b1; tick(); reset = 1'b0;
         checks++; if (bus.busy !== 1'b0 || bus.l1_enable !== 1'b0 || bus.l2_enable !== 1'b0)
            begin errors++; $display("FAIL midreset%0d_ctrl got busy %b l1 %b l2 %b want 0 0 0", phase, bus.busy, bus.l1_enable, bus.l2_enable); end
         checks++; if (bus.done !== 1'b0 || bus.error !== 1'b0)
            begin errors++; $display("FAIL midreset%0d_flags got done %b err %b want 0 0", phase, bus.done, bus.error); end
         checks++; if (bus.class_idx !== '0 || bus.class_score !== '0)
            begin errors++; $display("FAIL midreset%0d_result got %0d/%0d want 0/0", phase, bus.class_idx, bus.class_score); end
         repeat (15) tick();
         checks++; if (done_pulses != d0) begin errors++; $display("FAIL midreset%0d_abort got %0d done want 0", phase, done_pulses - d0); end
         $display("reset mid-run phase %0d checked", phase);
      end
      v = '{3, -2, 40, 7, 0, 1, 9, 12, 5, -8};
      run_inf(v, 5, 3, 0, 1'b0, 1'b0);
      checks++; if (obs_idx != 2 || obs_score != 40 || obs_lat != 10)
         begin errors++; $display("FAIL post_reset_run got %0d/%0d lat %0d want 2/40 lat 10", obs_idx, obs_score, obs_lat); end
   endtask

   task automatic test_back_to_back();
      vec_t a, b;
      for (int i = 0; i < N; i++) begin
         a[i] = DW'(int'($urandom_range(0, 40)) - 20);
         b[i] = DW'(int'($urandom_range(0, 40)) - 20);
      end
      a[4] = 16'sd50;
      b[7] = 16'sd60;
      run_inf(a, 3, 2, 0, 1'b0, 1'b0);
      checks++; if (obs_idx != 4 || obs_score != 50) begin errors++; $display("FAIL b2b_first got %0d/%0d want 4/50", obs_idx, obs_score); end
      run_inf(b, 2, 4, 0, 1'b0, 1'b0);
      checks++; if (obs_mid_idx != 4) begin errors++; $display("FAIL b2b_hold got %0d want 4", obs_mid_idx); end
      checks++; if (obs_idx != 7 || obs_score != 60) begin errors++; $display("FAIL b2b_second got %0d/%0d want 7/60", obs_idx, obs_score); end
      $display("back-to-back: idx 4 then %0d", obs_idx);
   endtask

   task automatic test_random();
      vec_t v;
      int e_idx, e_score;
      for (int t = 0; t < 12; t++) begin
         for (int i = 0; i < N; i++)
            v[i] = (t % 3 == 0) ? DW'($urandom) : DW'(int'($urandom_range(0, 8)) - 4);
         model(v, e_idx, e_score);
         run_inf(v, int'($urandom_range(1, 6)), int'($urandom_range(1, 6)), 0, t[0], 1'b0);
         checks++; if (obs_idx != e_idx || obs_score != e_score || obs_lat != 10 || obs_seq_bad)
            begin errors++; $display("FAIL rand%0d got %0d/%0d lat %0d want %0d/%0d lat 10", t, obs_idx, obs_score, obs_lat, e_idx, e_score); end
         $display("rand %0d: idx %0d score %0d", t, obs_idx, obs_score);
      end
   endtask

`ifdef MLP_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      int prev_idx, n, d0;
      prev_idx = int'(bus.class_idx);
      d0 = done_pulses;
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      n = 0;
      while (bus.l1_enable === 1'b1 && n < 100) begin n++; tick(); end
      checks++; if (n != 16) begin errors++; $display("FAIL timeout_cycles got %0d want 16", n); end
      checks++; if (bus.error !== 1'b1 || bus.l2_enable !== 1'b0) begin errors++; $display("FAIL timeout_flag got err %b l2 %b want 1 0", bus.error, bus.l2_enable); end
      repeat (6) tick();
      checks++; if (done_pulses - d0 != 1) begin errors++; $display("FAIL timeout_done got %0d want 1", done_pulses - d0); end
      checks++; if (int'(bus.class_idx) != prev_idx || bus.error !== 1'b1) begin errors++; $display("FAIL timeout_hold got idx %0d err %b want %0d 1", bus.class_idx, bus.error, prev_idx); end
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b want 0", bus.error); end
      reset = 1'b1; tick(); reset = 1'b0;
      $display("timeout: l1 cycles %0d", n);
   endtask
`endif

   initial begin
      reset = 1'b1;
      bus.start = 1'b0;
      bus.l1_done = 1'b0;
      bus.l2_done = 1'b0;
      for (int i = 0; i < N; i++) bus.l2_out[i] = '0;
      test_reset();
      test_basic();
      test_ties();
      test_ignored_inputs();
      test_reset_mid();
      test_back_to_back();
      test_random();
`ifdef MLP_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
